// File: rtl/pwm_multi_phase.sv
// Multi-channel phase-shifted PWM: a shared period counter, per-channel on/delay
// tick counts from a serial multiply/divide engine, and atomic shadow commit.
// Optional external period sync is enabled with `define PWM_MC_SYNC_IN_EN.
module pwm_multi_phase #(
  parameter int WIDTH    = 26,
  parameter int CHANNELS = 4,
  parameter int CH_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WIDTH-1:0]    cfg_n,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [13:0]         cfg_duty,
  input  logic [8:0]          cfg_phase,
  input  logic                cfg_commit,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start,
`ifdef PWM_MC_SYNC_IN_EN
  input  logic                sync_in,
`endif
  output logic                commit_pending
);
  localparam int PW = WIDTH + 14;
  localparam int VW = WIDTH + 1;
  localparam int SW = VW + 1;
  localparam int BW = $clog2(PW + 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV_ON, S_DIV_DLY, S_STORE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [13:0]      duty_q, duty_d;
  logic [8:0]       phase_q, phase_d;
  logic             commit_q, commit_d;
  logic [PW-1:0]    div_q, div_d;
  logic [PW-1:0]    b_q, b_d;
  logic [13:0]      rem_q, rem_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [VW-1:0]    on_q, on_d;

  logic [VW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] n_act_q, n_act_d;
  logic [WIDTH-1:0] shadow_n_q, shadow_n_d;
  logic [VW-1:0]    on_act_q [CHANNELS];
  logic [VW-1:0]    on_act_d [CHANNELS];
  logic [VW-1:0]    dly_act_q [CHANNELS];
  logic [VW-1:0]    dly_act_d [CHANNELS];
  logic [VW-1:0]    shadow_on_q [CHANNELS];
  logic [VW-1:0]    shadow_on_d [CHANNELS];
  logic [VW-1:0]    shadow_dly_q [CHANNELS];
  logic [VW-1:0]    shadow_dly_d [CHANNELS];
  logic             commit_pending_q, commit_pending_d;
  logic [CHANNELS-1:0] pwm_out_q, pwm_out_d;
  logic             period_start_q, period_start_d;

  logic [13:0]      divisor;
  logic [14:0]      step_rem_sh;
  logic [15:0]      step_sub;
  logic             step_qbit;
  logic [13:0]      step_rem;
  logic [PW-1:0]    step_div;
  logic [VW-1:0]    p_val;
  logic [VW-1:0]    dly_val;
  logic             wrap;
  logic [SW-1:0]    p_act;
  logic [SW-1:0]    s_sum;
  logic [SW-1:0]    cnt_x;
  logic [SW-1:0]    dly_x;
  logic             unused_ok;

  assign cfg_ready      = (state_q == S_IDLE) && !commit_pending_q;
  assign pwm_out        = pwm_out_q;
  assign period_start   = period_start_q;
  assign commit_pending = commit_pending_q;
  assign unused_ok      = step_sub[14];

  // One restoring-divide step: quotient bits shift into div_q as dividend bits leave
  always_comb begin
    divisor     = (state_q == S_DIV_DLY) ? 14'd360 : 14'd10000;
    step_rem_sh = {rem_q, div_q[PW-1]};
    step_sub    = {1'b0, step_rem_sh} - {2'b00, divisor};
    step_qbit   = ~step_sub[15];
    step_rem    = step_qbit ? step_sub[13:0] : step_rem_sh[13:0];
    step_div    = {div_q[PW-2:0], step_qbit};
    p_val       = VW'(n_q) + VW'(2);
    dly_val     = div_q[VW-1:0] + VW'(rem_q >= 14'd180);
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    ch_d     = ch_q;
    duty_d   = duty_q;
    phase_d  = phase_q;
    commit_d = commit_q;
    div_d    = div_q;
    b_d      = b_q;
    rem_d    = rem_q;
    bit_d    = bit_q;
    on_d     = on_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid && cfg_ready) begin
          n_d      = cfg_n;
          ch_d     = cfg_ch;
          duty_d   = (cfg_duty > 14'd10000) ? 14'd10000 : cfg_duty;
          phase_d  = (cfg_phase > 9'd359) ? 9'd359 : cfg_phase;
          commit_d = cfg_commit;
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        div_d   = PW'(duty_q) * PW'(p_val);
        b_d     = PW'(phase_q) * PW'(p_val);
        rem_d   = '0;
        bit_d   = '0;
        state_d = S_DIV_ON;
      end
      S_DIV_ON: begin
        if (bit_q == BW'(PW - 1)) begin
          // Round the on-time here so the same datapath can start the delay divide
          on_d    = step_div[VW-1:0] + VW'(step_rem >= 14'd5000);
          div_d   = b_q;
          rem_d   = '0;
          bit_d   = '0;
          state_d = S_DIV_DLY;
        end else begin
          div_d = step_div;
          rem_d = step_rem;
          bit_d = bit_q + BW'(1);
        end
      end
      S_DIV_DLY: begin
        div_d = step_div;
        rem_d = step_rem;
        bit_d = bit_q + BW'(1);
        if (bit_q == BW'(PW - 1)) begin
          state_d = S_STORE;
        end
      end
      S_STORE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Period counter, shadow staging and the atomic apply at the wrap
  always_comb begin
    cnt_d            = cnt_q;
    n_act_d          = n_act_q;
    shadow_n_d       = shadow_n_q;
    on_act_d         = on_act_q;
    dly_act_d        = dly_act_q;
    shadow_on_d      = shadow_on_q;
    shadow_dly_d     = shadow_dly_q;
    commit_pending_d = commit_pending_q;

    wrap = (cnt_q == (VW'(n_act_q) + VW'(1)));
`ifdef PWM_MC_SYNC_IN_EN
    wrap = wrap | sync_in;
`endif
    cnt_d = wrap ? '0 : cnt_q + VW'(1);

    if (wrap && commit_pending_q) begin
      n_act_d          = shadow_n_q;
      on_act_d         = shadow_on_q;
      dly_act_d        = shadow_dly_q;
      commit_pending_d = 1'b0;
    end

    if (state_q == S_STORE) begin
      shadow_n_d = n_q;
      for (int i = 0; i < CHANNELS; i++) begin
        if (ch_q == CH_W'(i)) begin
          shadow_on_d[i]  = on_q;
          shadow_dly_d[i] = dly_val;
        end
      end
      if (commit_q) begin
        commit_pending_d = 1'b1;
      end
    end
  end

  // Output law; the s > P branch covers a pulse that wraps past the period end
  always_comb begin
    pwm_out_d      = '0;
    s_sum          = '0;
    dly_x          = '0;
    p_act          = SW'(n_act_q) + SW'(2);
    cnt_x          = SW'(cnt_q);
    period_start_d = (cnt_q == '0);
    for (int i = 0; i < CHANNELS; i++) begin
      dly_x = SW'(dly_act_q[i]);
      s_sum = dly_x + SW'(on_act_q[i]);
      if (s_sum > p_act) begin
        pwm_out_d[i] = (cnt_x < (s_sum - p_act)) || (cnt_x >= dly_x);
      end else begin
        pwm_out_d[i] = (cnt_x >= dly_x) && (cnt_x < s_sum);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      n_q              <= '0;
      ch_q             <= '0;
      duty_q           <= '0;
      phase_q          <= '0;
      commit_q         <= 1'b0;
      div_q            <= '0;
      b_q              <= '0;
      rem_q            <= '0;
      bit_q            <= '0;
      on_q             <= '0;
      cnt_q            <= '0;
      n_act_q          <= '0;
      shadow_n_q       <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        on_act_q[i]     <= '0;
        dly_act_q[i]    <= '0;
        shadow_on_q[i]  <= '0;
        shadow_dly_q[i] <= '0;
      end
      commit_pending_q <= 1'b0;
      pwm_out_q        <= '0;
      period_start_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      n_q              <= n_d;
      ch_q             <= ch_d;
      duty_q           <= duty_d;
      phase_q          <= phase_d;
      commit_q         <= commit_d;
      div_q            <= div_d;
      b_q              <= b_d;
      rem_q            <= rem_d;
      bit_q            <= bit_d;
      on_q             <= on_d;
      cnt_q            <= cnt_d;
      n_act_q          <= n_act_d;
      shadow_n_q       <= shadow_n_d;
      on_act_q         <= on_act_d;
      dly_act_q        <= dly_act_d;
      shadow_on_q      <= shadow_on_d;
      shadow_dly_q     <= shadow_dly_d;
      commit_pending_q <= commit_pending_d;
      pwm_out_q        <= pwm_out_d;
      period_start_q   <= period_start_d;
    end
  end

endmodule
